// File: rtl/mux_scan_pkg.sv
// Shared definitions for the 4:1 mux channel scanner.
//   - scanner FSM state encoding (S_IDLE, S_SCAN, S_PRESENT)
//   - channel count, select width and dwell counter width
//   - first_chan(): lowest enabled channel of a mask
package mux_scan_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SCAN    = 2'd1,
        S_PRESENT = 2'd2
    } state_e;

    // Lowest set bit of the mask; 0 when the mask is empty so the select stays 2'b00.
    function automatic logic [SEL_W-1:0] first_chan(input logic [NUM_CH-1:0] mask);
        logic [SEL_W-1:0] ch;
        ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                ch = SEL_W'(i);
            end
        end
        return ch;
    endfunction

endpackage

// File: rtl/mux_scan_next_chan.sv
// Combinational next-channel finder for the mux channel scanner.
// Ports:
//   cur_i   current channel
//   mask_i  enabled-channel mask (bit i = channel i enabled)
//   next_o  next higher enabled channel (cur_i when none remain)
//   last_o  high when no enabled channel exists above cur_i
module mux_scan_next_chan
    import mux_scan_pkg::*;
(
    input  logic [SEL_W-1:0]  cur_i,
    input  logic [NUM_CH-1:0] mask_i,
    output logic [SEL_W-1:0]  next_o,
    output logic              last_o
);

    // Descending walk so the lowest qualifying channel is the one that sticks.
    always_comb begin
        next_o = cur_i;
        last_o = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i > int'(cur_i) && mask_i[i]) begin
                next_o = SEL_W'(i);
                last_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_channel_scanner.sv
// Select sequencer for a 4:1 mux: walks the enabled channels, holds each select for DWELL
// cycles, samples the mux output and presents the four samples as a frame with valid/ready.
// Optional feature macro: MUX_SCAN_MASK_EN (adds chan_mask_i; otherwise all channels scanned).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         begin a scan (honoured only in IDLE)
//   cont_i          continuous mode, sampled at frame handshake
//   chan_mask_i     per-channel enable, latched at scan start (MUX_SCAN_MASK_EN only)
//   mux_out_i       output of the driven mux
//   s0_o, s1_o      mux select LSB / MSB
//   frame_o         sampled frame, bit i = mux input i
//   frame_valid_o   frame_ready_i   frame handshake
//   busy_o          high whenever not IDLE
module mux_channel_scanner
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              cont_i,
`ifdef MUX_SCAN_MASK_EN
    input  logic [NUM_CH-1:0] chan_mask_i,
`endif
    input  logic              mux_out_i,
    output logic              s0_o,
    output logic              s1_o,
    output logic [NUM_CH-1:0] frame_o,
    output logic              frame_valid_o,
    input  logic              frame_ready_i,
    output logic              busy_o
);

    localparam logic [CNT_W-1:0] Reload = CNT_W'(DWELL - 1);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0] frame_q, frame_d;
    logic              valid_q, valid_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] mask_in;
    logic [SEL_W-1:0]  next_chan;
    logic              last_chan;
    logic              scan_go;

`ifdef MUX_SCAN_MASK_EN
    assign mask_in = chan_mask_i;
`else
    assign mask_in = '1;
`endif

    mux_scan_next_chan u_next_chan (
        .cur_i  (sel_q),
        .mask_i (mask_q),
        .next_o (next_chan),
        .last_o (last_chan)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        valid_d  = valid_q;
        mask_d   = mask_q;
        scan_go  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    scan_go = 1'b1;
                end
            end
            S_SCAN: begin
                if (mask_q == '0) begin
                    // Nothing to scan: publish an all-zero frame straight away.
                    frame_d = '0;
                    valid_d = 1'b1;
                    state_d = S_PRESENT;
                end else if (cnt_q == '0) begin
                    shadow_d[sel_q] = mux_out_i;
                    if (last_chan) begin
                        frame_d = shadow_d;
                        valid_d = 1'b1;
                        state_d = S_PRESENT;
                    end else begin
                        sel_d = next_chan;
                        cnt_d = Reload;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PRESENT: begin
                if (frame_ready_i) begin
                    valid_d = 1'b0;
                    if (cont_i) begin
                        scan_go = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        sel_d   = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = '0;
                valid_d = 1'b0;
            end
        endcase

        // Shared entry into SCAN, from IDLE or from a continuous-mode handshake.
        if (scan_go) begin
            state_d  = S_SCAN;
            mask_d   = mask_in;
            sel_d    = first_chan(mask_in);
            cnt_d    = Reload;
            shadow_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            frame_q  <= '0;
            valid_q  <= 1'b0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            valid_q  <= valid_d;
            mask_q   <= mask_d;
        end
    end

    assign s0_o          = sel_q[0];
    assign s1_o          = sel_q[1];
    assign frame_o       = frame_q;
    assign frame_valid_o = valid_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Self-checking bench for mux_channel_scanner. The 4:1 mux being driven is modelled
// behaviourally; expected select walks and frames come from the enabled-channel list.
module tb_mux_channel_scanner;

    localparam int unsigned DWELL = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       frame_ready = 1'b0;
    logic [3:0] chan_mask = 4'hF;
    logic [3:0] mux_in = 4'h0;
    logic       mux_out;
    logic       s0, s1, frame_valid, busy;
    logic [3:0] frame;

    int vectors = 0;
    int errors  = 0;

    // The 4:1 mux under control of the scanner.
    assign mux_out = mux_in[{s1, s0}];

    always #5 clk = ~clk;

    mux_channel_scanner #(.DWELL(DWELL)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .cont_i        (cont),
`ifdef MUX_SCAN_MASK_EN
        .chan_mask_i   (chan_mask),
`endif
        .mux_out_i     (mux_out),
        .s0_o          (s0),
        .s1_o          (s1),
        .frame_o       (frame),
        .frame_valid_o (frame_valid),
        .frame_ready_i (frame_ready),
        .busy_o        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] eff_mask(input logic [3:0] m);
`ifdef MUX_SCAN_MASK_EN
        return m;
`else
        return 4'hF;
`endif
    endfunction

    // Called just after the edge that entered SCAN. Checks the select walk, then the frame.
    task automatic check_scan(input logic [3:0] mask, input logic [3:0] din, input bit poke,
                              output logic [1:0] last_sel);
        int chs[$];
        int cycles;
        logic [1:0] es;
        es = 2'b00;
        for (int i = 0; i < 4; i++) if (mask[i]) chs.push_back(i);
        cycles = (chs.size() == 0) ? 1 : chs.size() * DWELL;
        for (int c = 0; c < cycles; c++) begin
            es = (chs.size() == 0) ? 2'b00 : 2'(chs[c / DWELL]);
            vectors++;
            if ({s1, s0} !== es || frame_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL scan_c%0d: sel=%b valid=%b busy=%b, expected sel=%b valid=0 busy=1",
                         c, {s1, s0}, frame_valid, busy, es);
            end
            if (poke) begin
                start = 1'($urandom_range(0, 1));
`ifdef MUX_SCAN_MASK_EN
                chan_mask = 4'($urandom);
`endif
            end
            tick();
        end
        start = 1'b0;
        chan_mask = mask;
        vectors++;
        if (frame_valid !== 1'b1 || frame !== (din & mask)) begin
            errors++;
            $display("FAIL scan_frame: valid=%b frame=%b, expected valid=1 frame=%b",
                     frame_valid, frame, din & mask);
        end
        last_sel = es;
    endtask

    task automatic hold_check(input int n, input logic [3:0] ef, input logic [1:0] es,
                              input bit poke);
        frame_ready = 1'b0;
        for (int c = 0; c < n; c++) begin
            vectors++;
            if (frame_valid !== 1'b1 || frame !== ef || busy !== 1'b1 || {s1, s0} !== es) begin
                errors++;
                $display("FAIL hold_c%0d: valid=%b frame=%b busy=%b sel=%b, expected 1 %b 1 %b",
                         c, frame_valid, frame, busy, {s1, s0}, ef, es);
            end
            if (poke) start = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
    endtask

    task automatic finish_idle(input logic [3:0] ef);
        cont = 1'b0;
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        vectors++;
        if (frame_valid !== 1'b0 || busy !== 1'b0 || {s1, s0} !== 2'b00 || frame !== ef) begin
            errors++;
            $display("FAIL to_idle: valid=%b busy=%b sel=%b frame=%b, expected 0 0 00 %b",
                     frame_valid, busy, {s1, s0}, frame, ef);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({s1, s0} !== 2'b00 || frame !== 4'h0 || frame_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: sel=%b frame=%b valid=%b busy=%b, expected 00 0000 0 0",
                     {s1, s0}, frame, frame_valid, busy);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [1:0] ls;
        mux_in = 4'b1101;
        frame_ready = 1'b1;
        pulse_start();
        check_scan(4'hF, 4'b1101, 1'b0, ls);
        finish_idle(4'b1101);
    endtask

    task automatic test_hold();
        logic [1:0] ls;
        logic [3:0] din;
        din = 4'($urandom);
        mux_in = din;
        pulse_start();
        check_scan(4'hF, din, 1'b0, ls);
        hold_check(5, din, ls, 1'b0);
        finish_idle(din);
    endtask

    task automatic test_back_to_back();
        logic [1:0] ls;
        logic [3:0] din;
        din = 4'($urandom);
        mux_in = din;
        cont = 1'b1;
        frame_ready = 1'b1;
        pulse_start();
        check_scan(4'hF, din, 1'b0, ls);
        for (int f = 0; f < 5; f++) begin
            din = ~din ^ 4'($urandom_range(0, 3));
            mux_in = din;
            tick();
            check_scan(4'hF, din, 1'b0, ls);
        end
        finish_idle(din);
    endtask

    task automatic test_start_ignored();
        logic [1:0] ls;
        logic [3:0] din;
        din = 4'($urandom);
        mux_in = din;
        pulse_start();
        check_scan(4'hF, din, 1'b1, ls);
        hold_check(4, din, ls, 1'b1);
        finish_idle(din);
    endtask

`ifdef MUX_SCAN_MASK_EN
    task automatic test_mask();
        logic [1:0] ls;
        logic [3:0] din;
        din = 4'b1010 | (4'($urandom) & 4'b0101);
        mux_in = din;
        chan_mask = 4'b1010;
        pulse_start();
        check_scan(4'b1010, din, 1'b1, ls);
        hold_check(2, 4'b1010, ls, 1'b0);
        finish_idle(4'b1010);
        chan_mask = 4'b0000;
        pulse_start();
        check_scan(4'b0000, din, 1'b0, ls);
        hold_check(2, 4'b0000, 2'b00, 1'b0);
        finish_idle(4'b0000);
        chan_mask = 4'hF;
    endtask
`endif

    task automatic test_reset_mid();
        logic [1:0] ls;
        logic [3:0] din;
        din = 4'($urandom);
        mux_in = din;
        pulse_start();
        for (int c = 0; c < 2 * DWELL; c++) tick();
        vectors++;
        if ({s1, s0} !== 2'b10) begin
            errors++;
            $display("FAIL mid_sel: sel=%b, expected 10", {s1, s0});
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({s1, s0} !== 2'b00 || frame !== 4'h0 || frame_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: sel=%b frame=%b valid=%b busy=%b, expected 00 0000 0 0",
                     {s1, s0}, frame, frame_valid, busy);
        end
        #2;
        rst_n = 1'b1;
        tick();
        din = 4'($urandom);
        mux_in = din;
        pulse_start();
        check_scan(4'hF, din, 1'b0, ls);
        finish_idle(din);
    endtask

    task automatic test_random();
        logic [1:0] ls;
        logic [3:0] din;
        logic [3:0] m;
        for (int r = 0; r < 10; r++) begin
            din = 4'($urandom);
            mux_in = din;
            chan_mask = 4'($urandom);
            m = eff_mask(chan_mask);
            pulse_start();
            check_scan(m, din, 1'b0, ls);
            hold_check(int'($urandom_range(0, 3)), din & m, ls, 1'b0);
            finish_idle(din & m);
        end
        chan_mask = 4'hF;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_start_ignored();
`ifdef MUX_SCAN_MASK_EN
        test_mask();
`endif
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
